can_bit_destuffer: RTL and testbench

- Bit-stream controller between the raw CAN receive line and the frame-decoding FSM.
- Runs once per sample point:
  - integrates onto the bus after reset;
  - detects SOF;
  - removes stuff bits inside the stuffed region;
  - flags stuff errors;
  - sequences the error flag and error delimiter back to bus idle.
- The frame decoder advances only on SP edges where DV=1.

---
 rtl/can_bit_destuffer.sv | 144 ++++++++++++++
 tb/tb_can_bit_destuffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer.sv
// CAN receive bit-stream front end: bus integration, SOF detect, stuff-bit removal,
// stuff-error detection and error flag / delimiter sequencing, all clocked by the sample point.
module can_bit_destuffer #(
  parameter int unsigned STUFF_LEN     = 5,
  parameter int unsigned ERR_FLAG_LEN  = 6,
  parameter int unsigned ERR_DELIM_LEN = 8,
  parameter int unsigned IDLE_LEN      = 11
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       STF_EN,
  input  logic       ERR_IN,
  output logic       RX_D,
  output logic       DV,
  output logic       STF_BIT,
  output logic       STF_ERR,
  output logic       ERROR,
  output logic       BUS_IDLE,
  output logic [7:0] STF_CNT
);

  typedef enum logic [2:0] {StInteg, StIdle, StFrame, StEflag, StEdelim} state_e;

  localparam logic [2:0] RunStuff  = 3'(STUFF_LEN);
  localparam logic [3:0] IdleLast  = 4'(IDLE_LEN - 1);
  localparam logic [3:0] EflagLast = 4'(ERR_FLAG_LEN - 1);
  localparam logic [3:0] DelimLast = 4'(ERR_DELIM_LEN + 3 - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [2:0]  run_q, run_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [3:0]  ecnt_q, ecnt_d;
  logic [7:0]  cnt_d;
  logic        dv_d, stf_bit_d, stf_err_d;

  logic stuff_slot, viol;
  assign stuff_slot = STF_EN && (run_q == RunStuff);
  assign viol       = stuff_slot && (RX == last_q);

  always_ff @(posedge SP or posedge reset) begin
    if (reset) state_q <= StInteg;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInteg:  if (RX && rcnt_q == IdleLast) state_d = StIdle;
      StIdle:   if (!RX) state_d = StFrame;
      StFrame: begin
        if (ERR_IN || viol) state_d = StEflag;
        else if (!STF_EN && RX && rcnt_q == IdleLast) state_d = StIdle;
      end
      StEflag:  if (ecnt_q == EflagLast) state_d = StEdelim;
      StEdelim: if (RX && rcnt_q == DelimLast) state_d = StIdle;
      default:  state_d = StInteg;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    run_d     = run_q;
    rcnt_d    = rcnt_q;
    ecnt_d    = ecnt_q;
    cnt_d     = STF_CNT;
    dv_d      = 1'b0;
    stf_bit_d = 1'b0;
    stf_err_d = 1'b0;
    unique case (state_q)
      StInteg: rcnt_d = (RX && rcnt_q != IdleLast) ? rcnt_q + 4'd1 : 4'd0;
      StIdle: begin
        rcnt_d = 4'd0;
        if (!RX) begin
          dv_d   = 1'b1;
          last_d = 1'b0;
          run_d  = 3'd1;
          cnt_d  = 8'd0;
        end
      end
      StFrame: begin
        ecnt_d = 4'd0;
        if (STF_EN) begin
          rcnt_d    = 4'd0;
          stf_err_d = viol;
          if (!ERR_IN && !viol) begin
            if (stuff_slot) begin
              stf_bit_d = 1'b1;
              cnt_d     = (STF_CNT == 8'hFF) ? 8'hFF : STF_CNT + 8'd1;
              last_d    = RX;
              run_d     = 3'd1;
            end else begin
              dv_d   = 1'b1;
              run_d  = (RX == last_q) ? run_q + 3'd1 : 3'd1;
              last_d = RX;
            end
          end
        end else begin
          // Unstuffed tail: run is parked at 0 so the next stuffed bit starts a fresh run.
          run_d  = 3'd0;
          last_d = RX;
          rcnt_d = (RX && rcnt_q != IdleLast) ? rcnt_q + 4'd1 : 4'd0;
          dv_d   = !ERR_IN && !(RX && rcnt_q == IdleLast);
        end
      end
      StEflag: begin
        ecnt_d = (ecnt_q == EflagLast) ? 4'd0 : ecnt_q + 4'd1;
        rcnt_d = 4'd0;
      end
      StEdelim: rcnt_d = (RX && rcnt_q != DelimLast) ? rcnt_q + 4'd1 : 4'd0;
      default: ;
    endcase
  end

  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      run_q    <= 3'd0;
      rcnt_q   <= 4'd0;
      ecnt_q   <= 4'd0;
      RX_D     <= 1'b1;
      DV       <= 1'b0;
      STF_BIT  <= 1'b0;
      STF_ERR  <= 1'b0;
      ERROR    <= 1'b0;
      BUS_IDLE <= 1'b0;
      STF_CNT  <= 8'd0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      rcnt_q   <= rcnt_d;
      ecnt_q   <= ecnt_d;
      RX_D     <= RX;
      DV       <= dv_d;
      STF_BIT  <= stf_bit_d;
      STF_ERR  <= stf_err_d;
      ERROR    <= (state_d == StEflag) || (state_d == StEdelim);
      BUS_IDLE <= (state_d == StIdle);
      STF_CNT  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Bench for can_bit_destuffer: vector table through a scoreboard queue plus
// hand-written saturation and mid-frame reset sequences.
module tb_can_bit_destuffer;

  logic       SP = 1'b0;
  logic       reset = 1'b1;
  logic       RX = 1'b1, STF_EN = 1'b0, ERR_IN = 1'b0;
  logic       RX_D, DV, STF_BIT, STF_ERR, ERROR, BUS_IDLE;
  logic [7:0] STF_CNT;

  can_bit_destuffer dut (
    .SP(SP), .reset(reset), .RX(RX), .STF_EN(STF_EN), .ERR_IN(ERR_IN),
    .RX_D(RX_D), .DV(DV), .STF_BIT(STF_BIT), .STF_ERR(STF_ERR), .ERROR(ERROR),
    .BUS_IDLE(BUS_IDLE), .STF_CNT(STF_CNT)
  );

  always #5 SP = ~SP;

  typedef struct {
    string      name;
    logic       rx, en, err;
    logic       dv, sb, se, er, bi;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  localparam logic [13:0] ResetVals = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

  function automatic vec_t v(string n, logic rx, logic en, logic err, logic dv, logic sb,
                             logic se, logic er, logic bi, logic [7:0] cnt);
    vec_t t;
    t.name = n; t.rx = rx; t.en = en; t.err = err;
    t.dv = dv; t.sb = sb; t.se = se; t.er = er; t.bi = bi; t.cnt = cnt;
    return t;
  endfunction

  function automatic logic [13:0] outs();
    return {RX_D, DV, STF_BIT, STF_ERR, ERROR, BUS_IDLE, STF_CNT};
  endfunction

  task automatic cmp(string name, logic [13:0] act, logic [13:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got rxd/dv/sb/se/err/idle/cnt=%b required %b (t=%0t)",
               name, act, req, $time);
    end
  endtask

  // Drive one bit, queue its expectation, and score the DUT output after the edge.
  task automatic apply(vec_t t);
    vec_t e;
    RX = t.rx; STF_EN = t.en; ERR_IN = t.err;
    exp_q.push_back(t);
    @(posedge SP);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty: got no entry required one");
    end else begin
      e = exp_q.pop_front();
      cmp(e.name, outs(), {e.rx, e.dv, e.sb, e.se, e.er, e.bi, e.cnt});
    end
  endtask

  task automatic add_n(int n, vec_t t);
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endtask

  // Error flag then a clean delimiter back to idle.
  task automatic add_err_tail(logic [7:0] cnt);
    add_n(6,  v("eflag", 0, 0, 1, 0, 0, 0, 1, 0, cnt));
    add_n(10, v("edelim", 1, 0, 0, 0, 0, 0, 1, 0, cnt));
    tbl.push_back(v("edelim_end", 1, 0, 0, 0, 0, 0, 0, 1, cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       lvl;
    int         nst;
    logic [7:0] ec;

    // Integration
    add_n(10, v("integ_rec", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("integ_dom", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_n(10, v("integ_rec2", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("integ_idle", 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v("idle_err_in_ignored", 1, 0, 1, 0, 0, 0, 0, 1, 0));
    // Stuff removal, then stuff error
    tbl.push_back(v("sof", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    add_n(4, v("data0", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v("stuff_bit", 1, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v("after_stuff", 1, 1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v("data0b", 0, 1, 0, 1, 0, 0, 0, 0, 1));
    add_n(5, v("run_ones", 1, 1, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v("stuff_viol", 1, 1, 0, 0, 0, 1, 1, 0, 1));
    add_err_tail(8'd1);
    // Fresh run after STF_EN 0->1, then unstuffed tail
    tbl.push_back(v("sof2", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    add_n(3, v("d0", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    add_n(2, v("nostuff0", 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add_n(5, v("fresh_run", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v("stuff_bit2", 1, 1, 0, 0, 1, 0, 0, 0, 1));
    add_n(10, v("tail", 1, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v("tail_end", 1, 0, 0, 0, 0, 0, 0, 1, 1));
    // Decoder error with a dominant bit at delimiter position 4
    tbl.push_back(v("sof3", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v("d1", 1, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v("err_in", 1, 1, 1, 0, 0, 0, 1, 0, 0));
    add_n(6, v("eflag2", 1, 0, 1, 0, 0, 0, 1, 0, 0));
    add_n(3, v("delim_rec", 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v("delim_dom", 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add_n(10, v("delim_fresh", 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v("delim_end", 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // ERR_IN coinciding with a stuff violation
    tbl.push_back(v("sof4", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    add_n(4, v("d0c", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v("viol_and_err", 0, 1, 1, 0, 0, 1, 1, 0, 0));
    add_err_tail(8'd0);

    #12;
    cmp("reset_values", outs(), ResetVals);
    @(negedge SP);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // STF_CNT saturation over 256 stuff bits
    apply(v("sat_sof", 0, 1, 0, 1, 0, 0, 0, 0, 0));
    lvl = 1'b0;
    nst = 0;
    for (int g = 0; g < 256; g++) begin
      ec = (nst > 255) ? 8'd255 : 8'(nst);
      for (int k = 0; k < 4; k++) apply(v("sat_data", lvl, 1, 0, 1, 0, 0, 0, 0, ec));
      lvl = ~lvl;
      nst++;
      ec = (nst > 255) ? 8'd255 : 8'(nst);
      apply(v("sat_stuff", lvl, 1, 0, 0, 1, 0, 0, 0, ec));
    end
    for (int k = 0; k < 4; k++) apply(v("pre_reset", lvl, 1, 0, 1, 0, 0, 0, 0, 8'd255));

    // Asynchronous reset with run at the stuff limit
    #2;
    reset = 1'b1;
    #1;
    cmp("reset_mid_stuff", outs(), ResetVals);
    @(posedge SP);
    #1;
    cmp("reset_held", outs(), ResetVals);
    @(negedge SP);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) apply(v("reinteg", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(v("reinteg_idle", 1, 0, 0, 0, 0, 0, 0, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
